// File: rtl/microseq_pkg.sv
// Shared types and control-word layout for the microcode sequencer.
// Word layout, MSB first: {last, y_sel, en_y, en_x, op_sel[1:0], imm[IMM_W-1:0]}.
package microseq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OpNop  = 2'd0,
        OpNot  = 2'd1,
        OpAdd  = 2'd2,
        OpPass = 2'd3
    } op_e;

    function automatic int unsigned cw_width(input int unsigned imm_w);
        return imm_w + 6;
    endfunction

    function automatic int unsigned last_pos(input int unsigned imm_w);
        return imm_w + 5;
    endfunction

    function automatic int unsigned y_sel_pos(input int unsigned imm_w);
        return imm_w + 4;
    endfunction

    function automatic int unsigned en_y_pos(input int unsigned imm_w);
        return imm_w + 3;
    endfunction

    function automatic int unsigned en_x_pos(input int unsigned imm_w);
        return imm_w + 2;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned imm_w);
        return imm_w;
    endfunction

endpackage

// File: rtl/microseq_if.sv
// Host/datapath signal bundle for microseq_ctrl.
// The step input exists only when MICROSEQ_STEP_EN is defined.
interface microseq_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IMM_W = 8
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = IMM_W + 6;

    logic             prog_we;
    logic [AW-1:0]    prog_addr;
    logic [CW-1:0]    prog_data;
    logic             start;
`ifdef MICROSEQ_STEP_EN
    logic             step;
`endif
    logic             busy;
    logic             done;
    logic [1:0]       op_sel;
    logic             en_x;
    logic             en_y;
    logic             y_sel;
    logic [IMM_W-1:0] y_imm;

    modport master (
`ifdef MICROSEQ_STEP_EN
        output step,
`endif
        output prog_we, prog_addr, prog_data, start,
        input  busy, done, op_sel, en_x, en_y, y_sel, y_imm
    );

    modport slave (
`ifdef MICROSEQ_STEP_EN
        input  step,
`endif
        input  prog_we, prog_addr, prog_data, start,
        output busy, done, op_sel, en_x, en_y, y_sel, y_imm
    );

endinterface

// File: rtl/microseq_prog_mem.sv
// DEPTH x CW program register file: synchronous write, asynchronous read,
// synchronous clear on reset.
module microseq_prog_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 14,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [CW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [CW-1:0] rdata_o
);

    logic [DEPTH-1:0][CW-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/microseq_ctrl.sv
// Programmable microcode sequencer driving the x/y/ALU datapath.
// Optional single-step gating via MICROSEQ_STEP_EN.
module microseq_ctrl
    import microseq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IMM_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    microseq_if.slave  bus
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = cw_width(IMM_W);
    localparam int unsigned LastPos = last_pos(IMM_W);
    localparam int unsigned YSelPos = y_sel_pos(IMM_W);
    localparam int unsigned EnYPos  = en_y_pos(IMM_W);
    localparam int unsigned EnXPos  = en_x_pos(IMM_W);
    localparam int unsigned OpLsb   = op_lsb(IMM_W);

    state_e           state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [CW-1:0]    word;
    logic             mem_we;
    logic             step_ok;
    logic             at_end;

    logic             busy, done, en_x, en_y, y_sel;
    logic [1:0]       op_sel;
    logic [IMM_W-1:0] y_imm;

    // Program memory is locked while a program is running.
    assign mem_we = bus.prog_we && (state_q != StRun);

`ifdef MICROSEQ_STEP_EN
    assign step_ok = bus.step;
`else
    assign step_ok = 1'b1;
`endif

    assign at_end = word[LastPos] || (pc_q == AW'(DEPTH - 1));

    microseq_prog_mem #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_prog_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (mem_we),
        .waddr_i (bus.prog_addr),
        .wdata_i (bus.prog_data),
        .raddr_i (pc_q),
        .rdata_o (word)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        busy    = 1'b0;
        done    = 1'b0;
        op_sel  = 2'b00;
        en_x    = 1'b0;
        en_y    = 1'b0;
        y_sel   = 1'b0;
        y_imm   = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    pc_d    = '0;
                end
            end
            StRun: begin
                busy   = 1'b1;
                op_sel = word[OpLsb +: 2];
                y_sel  = word[YSelPos];
                y_imm  = word[IMM_W-1:0];
                en_x   = word[EnXPos] && step_ok;
                en_y   = word[EnYPos] && step_ok;
                if (step_ok) begin
                    if (at_end) begin
                        state_d = StDone;
                        pc_d    = '0;
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.op_sel = op_sel;
    assign bus.en_x   = en_x;
    assign bus.en_y   = en_y;
    assign bus.y_sel  = y_sel;
    assign bus.y_imm  = y_imm;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Randomized self-checking bench for microseq_ctrl against a program-walking
// reference model; exercises MICROSEQ_STEP_EN when that macro is defined.
module tb_microseq_ctrl;
    import microseq_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = IMM_W + 6;
    localparam int unsigned LastPos = IMM_W + 5;
    localparam int unsigned YSelPos = IMM_W + 4;
    localparam int unsigned EnYPos  = IMM_W + 3;
    localparam int unsigned EnXPos  = IMM_W + 2;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    logic [CW-1:0] mem_m [DEPTH];
    logic [7:0]    x_dp, y_dp;

    always #5 clk = ~clk;

    microseq_if #(.DEPTH(DEPTH), .IMM_W(IMM_W)) bus ();

    microseq_ctrl #(
        .DEPTH (DEPTH),
        .IMM_W (IMM_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk(input bit last, input bit ysel, input bit eny,
                                          input bit enx, input logic [1:0] op,
                                          input logic [IMM_W-1:0] imm);
        return {last, ysel, eny, enx, op, imm};
    endfunction

    function automatic logic [31:0] outs();
        return 32'({bus.busy, bus.done, bus.op_sel, bus.en_x, bus.en_y, bus.y_sel, bus.y_imm});
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [CW-1:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        @(posedge clk); #1;
        bus.prog_we   = 1'b0;
        mem_m[a]      = d;
    endtask

    // Runs whatever the model says is in memory; noisy adds writes/starts that must be ignored.
    task automatic run_prog(input bit noisy, input bit allow_step);
        int            ptr;
        bit            fin;
        bit            stp;
        logic [CW-1:0] w;
        logic [7:0]    alu;
        logic [AW-1:0] wa;
        logic [CW-1:0] wd;
        bit            wr;
        ptr  = 0;
        fin  = 1'b0;
        x_dp = 8'h00;
        y_dp = 8'h00;
        bus.start = 1'b1;
        wr = noisy && ($urandom_range(0, 1) == 1);
        if (wr) begin
            wa = AW'($urandom);
            wd = CW'($urandom);
            bus.prog_we   = 1'b1;
            bus.prog_addr = wa;
            bus.prog_data = wd;
            mem_m[wa]     = wd;
        end
        @(negedge clk);
        check("start_cycle", outs(), 32'h0);
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        for (int c = 0; c < 4 * DEPTH + 8 && !fin; c++) begin
            stp = 1'b1;
`ifdef MICROSEQ_STEP_EN
            if (allow_step) stp = ($urandom_range(0, 2) != 0) || (c == 0);
            bus.step = stp;
`endif
            if (noisy) begin
                bus.start     = 1'($urandom_range(0, 1));
                bus.prog_we   = 1'($urandom_range(0, 1));
                bus.prog_addr = AW'($urandom);
                bus.prog_data = CW'($urandom);
            end
            @(negedge clk);
            w = mem_m[ptr];
            check("run_busy", 32'({bus.busy, bus.done}), 32'h2);
            check("run_ctl", 32'({bus.op_sel, bus.y_sel, bus.y_imm}),
                  32'({w[IMM_W +: 2], w[YSelPos], w[IMM_W-1:0]}));
            check("run_en", 32'({bus.en_x, bus.en_y}),
                  stp ? 32'({w[EnXPos], w[EnYPos]}) : 32'h0);
            case (bus.op_sel)
                2'd1:    alu = ~x_dp;
                2'd2:    alu = x_dp + y_dp;
                2'd3:    alu = y_dp;
                default: alu = 8'h00;
            endcase
            if (bus.en_y) y_dp = bus.y_sel ? bus.y_imm : alu;
            if (bus.en_x) x_dp = alu;
            if (stp) begin
                if (w[LastPos] || ptr == DEPTH - 1) fin = 1'b1;
                else ptr++;
            end
            @(posedge clk); #1;
        end
        if (!fin) check("run_bound", 32'h0, 32'h1);
        // DONE cycle: start must be ignored, a write must land.
        bus.start   = noisy;
        bus.prog_we = 1'b0;
`ifdef MICROSEQ_STEP_EN
        bus.step = 1'b0;
`endif
        wr = noisy && ($urandom_range(0, 1) == 1);
        if (wr) begin
            wa = AW'($urandom);
            wd = CW'($urandom);
            bus.prog_we   = 1'b1;
            bus.prog_addr = wa;
            bus.prog_data = wd;
        end
        @(negedge clk);
        check("done_pulse", outs(), 32'({2'b01, 13'h0}) << (IMM_W - 8));
        @(posedge clk); #1;
        if (wr) mem_m[wa] = wd;
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        @(negedge clk);
        check("post_done", outs(), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.start     = 1'b0;
`ifdef MICROSEQ_STEP_EN
        bus.step      = 1'b0;
`endif
        clear_model();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(negedge clk);
        check("reset_outs", outs(), 32'h0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        reset     = 1'b0;

        // Zero program right after reset: DEPTH NOP cycles then done.
        run_prog(1'b0, 1'b0);

        // Additive-inverse program.
        write_word(3'd0, mk(0, 1, 1, 0, OpNop, 8'd5));
        write_word(3'd1, mk(0, 0, 0, 1, OpPass, 8'd0));
        write_word(3'd2, mk(0, 0, 0, 1, OpNot, 8'd0));
        write_word(3'd3, mk(0, 1, 1, 0, OpNop, 8'd1));
        write_word(3'd4, mk(0, 0, 0, 1, OpAdd, 8'd0));
        write_word(3'd5, mk(0, 1, 1, 0, OpNop, 8'd5));
        write_word(3'd6, mk(1, 0, 0, 1, OpAdd, 8'd0));
        run_prog(1'b0, 1'b0);
        check("inverse_x", 32'(x_dp), 32'h00);
        check("inverse_y", 32'(y_dp), 32'h05);

        // Reset during the fourth RUN cycle.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_model();
        @(negedge clk);
        check("reset_mid_run", outs(), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_no_done", outs(), 32'h0);
        @(posedge clk); #1;
        run_prog(1'b0, 1'b0);

        // Random programs with noisy writes/starts while running.
        for (int it = 0; it < 10; it++) begin
            int nw;
            nw = $urandom_range(1, DEPTH);
            for (int k = 0; k < nw; k++) begin
                logic [CW-1:0] d;
                d = CW'($urandom);
                d[LastPos] = ($urandom_range(0, 3) == 0);
                write_word(AW'($urandom), d);
            end
            run_prog(1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/microseq_ctrl.md
Name: microseq_ctrl

Overview:
- Programmable microcode sequencer for the simple x/y/ALU datapath.
- Generalises the fixed seven-state datapath controller: the control-word sequence lives in a writable program memory of DEPTH entries.
- Adds a start/busy/done handshake and an immediate field for the y-register constant.
- Sits between the top-level controller (load program, start) and the datapath (op_sel, en_x, en_y, y_sel, y_imm).

Parameters:
- DEPTH, 8, number of microinstruction entries (power of two, >= 2).
- IMM_W, 8, width of immediate constant driven to the datapath y mux.
- AW, $clog2(DEPTH), program address width (derived, not overridden).
- CW, IMM_W+6, control word width (derived).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- prog_we  input  1  program-memory write strobe
- prog_addr  input  AW  program write address
- prog_data  input  CW  control word {last, y_sel, en_y, en_x, op_sel[1:0], imm[IMM_W-1:0]} (MSB first)
- start  input  1  begin executing from address 0
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the final microinstruction
- op_sel  output  2  ALU op to datapath
- en_x  output  1  x register load enable
- en_y  output  1  y register load enable
- y_sel  output  1  y mux select (1 = immediate)
- y_imm  output  IMM_W  immediate constant

Behaviour:
- State: FSM with IDLE, RUN and DONE; pc is AW bits. Program memory is DEPTH x CW registers.
- Reset:
  - state=IDLE, pc=0, all memory words cleared to zero (NOP, last=0).
  - All outputs 0.
- IDLE:
  - All datapath outputs 0; busy=0; done=0.
  - start=1 -> RUN next cycle with pc=0.
- RUN:
  - busy=1. Outputs decoded combinationally from mem[pc]; each word is applied for exactly one cycle.
  - If mem[pc].last=1 or pc==DEPTH-1 -> DONE next cycle, pc<=0. Otherwise pc<=pc+1.
  - Latency: start cycle + N cycles of RUN for an N-word program (N>=1); done is asserted in cycle N+1 after start.
- DONE:
  - done=1 for one cycle; datapath outputs 0; -> IDLE.
- Program writes:
  - prog_we honoured only in IDLE or DONE. Writes while busy=1 are dropped silently.
  - A write and a start in the same IDLE cycle: write commits; execution starts next cycle and sees the new word.
- start while busy or in DONE: ignored, no queuing.
- Reset mid-RUN: immediate return to IDLE next edge, memory cleared, no done pulse.
- Zero program (after reset): running executes DEPTH NOP cycles, then done.
- Enables for the same cycle are taken verbatim from the word. en_x and en_y both set is legal; the datapath resolves it.

Optional Feature:
- MICROSEQ_STEP_EN:
  - When defined: adds input `step` (1 bit). In RUN, pc advances and en_x/en_y pass through only in cycles with step=1. With step=0, pc holds, en_x=en_y=0, and op_sel/y_sel/y_imm still reflect mem[pc].
  - The IDLE->RUN and DONE transitions are unaffected by step.
  - When undefined: no step port; behaviour as above, one word per cycle.

Decomposition:
- Shared package microseq_pkg:
  - state encodings IDLE/RUN/DONE
  - op_sel codes: OP_NOP=0, OP_NOT=1, OP_ADD=2, OP_PASS=3
  - control-word field bit positions as functions of IMM_W
- One sub-module: microseq_prog_mem (DEPTH x CW register file, sync write, async read, sync clear on reset).

Test Plan:
- Load 7-word additive-inverse program: {y<=imm 5; x<=y; x<=~x; y<=imm 1; x<=x+y; y<=imm 5; x<=x+y, last}, then start -> 7 RUN cycles with op_sel 0,3,1,0,2,0,2, y_imm 5,-,-,1,-,5,-. Done pulses in cycle 8 and a datapath model gives x=0xFB+5=0x00.
- Reset immediately followed by start -> busy high for 8 cycles, all enables 0, done in cycle 9.
- Write to addr 2 while busy -> dropped; re-run shows the original word at pc=2.
- Pulse start in RUN cycle 3 -> no restart; done timing unchanged.
- Assert reset in RUN cycle 4 -> busy=0 next cycle, no done, memory reads back zero.
- MICROSEQ_STEP_EN: step pattern 1,0,0,1,… -> pc holds during step=0 cycles, en_x=en_y=0 in those cycles, and done follows the last stepped word.
